// File: rtl/data_mem_slave.sv
// data_mem_slave: word-organised data RAM answering a req/gnt/r_valid data port.
// The grant delay (GNT_DELAY) and the response latency (RD_LATENCY) are programmable.
// Only one transaction can be outstanding at a time.
// Optional macro DMEM_ERR_EN adds the data_err port. With it, misaligned and
// out-of-range accesses are rejected.
module data_mem_slave #(
  parameter int DEPTH      = 1024,
  parameter int GNT_DELAY  = 0,
  parameter int RD_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        data_req,
  output logic        data_gnt,
  output logic        data_r_valid,
  input  logic        data_write_enable,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic [31:0] data_rdata
`ifdef DMEM_ERR_EN
  ,
  output logic        data_err
`endif
);

  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] GD = 4'(GNT_DELAY);
  localparam logic [3:0] RL = 4'(RD_LATENCY);

  typedef enum logic [1:0] {IDLE, GWAIT, LAT} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        lcnt_q, lcnt_d;
  logic              r_valid_q, r_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       resp_q, resp_d;
  logic              gnt_raw;
  logic              acc_err;
  logic              wr_en;
  logic [AW-1:0]     idx;
  logic [31:0]       mem [DEPTH];

  // Word index; the upper address bits alias, so the address wraps modulo DEPTH*4.
  assign idx = data_addr[AW+1:2];

`ifdef DMEM_ERR_EN
  logic resp_err_q, resp_err_d;
  logic err_q, err_d;

  // Reject misaligned or out-of-range addresses instead of aliasing them.
  assign acc_err = (data_addr[1:0] != 2'b00) || ((data_addr >> (AW + 2)) != 32'd0);
`else
  logic unused_addr_bits;

  assign acc_err          = 1'b0;
  assign unused_addr_bits = ^{data_addr[31:AW+2], data_addr[1:0]};
`endif

  // Grant is suppressed while reset is asserted, so nothing commits during reset.
  assign data_gnt = gnt_raw & ~RES;
  assign wr_en    = data_gnt & data_write_enable & ~acc_err;

  // Handshake FSM next state: grant wait counting, then response latency counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lcnt_d  = lcnt_q;
    gnt_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_req) begin
          if (GD == 4'd0) begin
            gnt_raw = 1'b1;
          end else begin
            state_d = GWAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      GWAIT: begin
        if (!data_req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == GD) begin
          gnt_raw = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      LAT: begin
        if (lcnt_q == RL) begin
          state_d = IDLE;
          lcnt_d  = 4'd0;
        end else begin
          lcnt_d = lcnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (gnt_raw) begin
      state_d = LAT;
      cnt_d   = 4'd0;
      lcnt_d  = 4'd1;
    end
  end

  // Response data is captured at grant and published to data_rdata only with r_valid.
  // Otherwise data_rdata keeps its last value.
  always_comb begin
    resp_d = resp_q;
    if (data_gnt) begin
      resp_d = (data_write_enable || acc_err) ? 32'd0 : mem[idx];
    end
    r_valid_d = (state_d == LAT) && (lcnt_d == RL);
    rdata_d   = r_valid_d ? resp_d : rdata_q;
  end

`ifdef DMEM_ERR_EN
  // The error flag travels with the response and is shown only on the r_valid cycle.
  always_comb begin
    resp_err_d = data_gnt ? acc_err : resp_err_q;
    err_d      = r_valid_d & resp_err_d;
  end

  // Error response registers.
  always_ff @(posedge CLK) begin
    resp_err_q <= resp_err_d;
    if (RES) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign data_err = err_q;
`endif

  // Control state and output registers.
  // A reset mid-transaction drops the pending response.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      lcnt_q    <= 4'd0;
      r_valid_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lcnt_q    <= lcnt_d;
      r_valid_q <= r_valid_d;
      rdata_q   <= rdata_d;
    end
  end

  // The response holding register is not reset; it is only consumed after a grant.
  always_ff @(posedge CLK) begin
    resp_q <= resp_d;
  end

  // Byte-masked RAM write at the grant edge. RAM contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be[i]) mem[idx][8*i +: 8] <= data_wdata[8*i +: 8];
      end
    end
  end

  assign data_r_valid = r_valid_q;
  assign data_rdata   = rdata_q;

endmodule

// File: tb/tb_data_mem_slave.sv
// Self-checking bench for data_mem_slave.
// Instance 0 uses the defaults (GNT_DELAY=0, RD_LATENCY=1).
// Instance 1 uses GNT_DELAY=3 and RD_LATENCY=2.
// The bench follows the DMEM_ERR_EN macro.
module tb_data_mem_slave;

  logic        CLK = 1'b0;
  logic        res   [2];
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        gnt   [2];
  logic        rv    [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  data_mem_slave #(.DEPTH(1024), .GNT_DELAY(0), .RD_LATENCY(1)) u_dut0 (
    .CLK(CLK), .RES(res[0]), .data_req(req[0]), .data_gnt(gnt[0]), .data_r_valid(rv[0]),
    .data_write_enable(we[0]), .data_addr(addr[0]), .data_wdata(wdata[0]), .data_be(be[0]),
    .data_rdata(rdata[0])
`ifdef DMEM_ERR_EN
    , .data_err(err[0])
`endif
  );

  data_mem_slave #(.DEPTH(1024), .GNT_DELAY(3), .RD_LATENCY(2)) u_dut1 (
    .CLK(CLK), .RES(res[1]), .data_req(req[1]), .data_gnt(gnt[1]), .data_r_valid(rv[1]),
    .data_write_enable(we[1]), .data_addr(addr[1]), .data_wdata(wdata[1]), .data_be(be[1]),
    .data_rdata(rdata[1])
`ifdef DMEM_ERR_EN
    , .data_err(err[1])
`endif
  );

`ifndef DMEM_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  b;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] mm  [2][1024];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Full transaction. Request attributes stay asserted through the latency phase,
  // so any grant during LAT is caught. The task returns one cycle after r_valid.
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, output logic [31:0] rd, output logic er,
                     output int gn, output int lt, output int bad);
    bad = 0; gn = 0; lt = 0; rd = '0; er = 1'b0;
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (rv[d]) bad++;
      if (gnt[d]) begin gn = i; break; end
      @(posedge CLK); #1;
    end
    if (gn != 0) begin
      @(posedge CLK); #1;
      for (int k = 1; k <= 40; k++) begin
        @(negedge CLK);
        if (gnt[d]) bad++;
        if (rv[d]) begin lt = k; rd = rdata[d]; er = err[d]; break; end
        @(posedge CLK); #1;
      end
      @(posedge CLK); #1;
    end
    req[d] = 1'b0;
  endtask

  task automatic wait_gnt(input int d, output int gn);
    gn = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (gnt[d]) begin gn = i; break; end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, wd, a;
    logic [3:0]  b;
    logic        er, w;
    int          gn, lt, bad, ix, egn, elt;
    bit          eon;

`ifdef DMEM_ERR_EN
    eon = 1'b1;
`else
    eon = 1'b0;
`endif
    tbl[0] = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 32'h10,   32'h11223344, 4'h5, 32'h0, 1'b0};
    tbl[3] = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDE22BE44, 1'b0};
    tbl[4] = '{1'b1, 32'h04,   32'h12345678, 4'hF, 32'h0, 1'b0};
    tbl[5] = '{1'b1, 32'h1004, 32'hA5A5A5A5, 4'hF, 32'h0, eon};
    tbl[6] = '{1'b0, 32'h04,   32'h0,        4'hF, eon ? 32'h12345678 : 32'hA5A5A5A5, 1'b0};
    tbl[7] = '{1'b0, 32'h06,   32'h0,        4'hF, eon ? 32'h0 : 32'hA5A5A5A5, eon};
    tbl[8] = '{1'b1, 32'hFFC,  32'h0BADF00D, 4'hF, 32'h0, 1'b0};
    tbl[9] = '{1'b0, 32'hFFC,  32'h0,        4'hF, 32'h0BADF00D, 1'b0};

    for (int d = 0; d < 2; d++) begin
      res[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
    end
    repeat (3) @(posedge CLK);
    #1;
    res[0] = 1'b0; res[1] = 1'b0;
    @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset gnt d%0d", d), gnt[d], 0);
      chk($sformatf("reset r_valid d%0d", d), rv[d], 0);
      chk($sformatf("reset rdata d%0d", d), rdata[d], 0);
      chk($sformatf("reset err d%0d", d), err[d], 0);
    end
    @(posedge CLK); #1;

    // Directed vectors on the default instance.
    for (int i = 0; i < 10; i++) begin
      txn(0, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].b, rd, er, gn, lt, bad);
      chk($sformatf("tbl%0d gnt_cycle", i), gn, 1);
      chk($sformatf("tbl%0d latency", i), lt, 1);
      chk($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d err", i), er, tbl[i].exp_er);
      chk($sformatf("tbl%0d protocol", i), bad, 0);
    end
    @(negedge CLK);
    chk("rdata hold", rdata[0], 32'h0BADF00D);
    @(posedge CLK); #1;

    // Grant delay and latency on instance 1.
    txn(1, 1'b1, 32'h20, 32'h600DCAFE, 4'hF, rd, er, gn, lt, bad);
    chk("gd3 write gnt_cycle", gn, 4);
    chk("gd3 write latency", lt, 2);
    chk("gd3 write rdata", rd, 0);
    txn(1, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, gn, lt, bad);
    chk("gd3 read gnt_cycle", gn, 4);
    chk("gd3 read latency", lt, 2);
    chk("gd3 read rdata", rd, 32'h600DCAFE);
    chk("gd3 protocol", bad, 0);

    // Request abandoned after two cycles: no grant, no response, RAM unchanged.
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h0; be[1] = 4'hF;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("abort gnt", gnt[1], 0);
      @(posedge CLK); #1;
    end
    req[1] = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (gnt[1] || rv[1]) bad++;
      @(posedge CLK); #1;
    end
    chk("abort quiet", bad, 0);
    txn(1, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, gn, lt, bad);
    chk("abort ram unchanged", rd, 32'h600DCAFE);

    // Reset in LAT after a read grant drops the response.
    txn(1, 1'b1, 32'h44, 32'h5555AAAA, 4'hF, rd, er, gn, lt, bad);
    txn(1, 1'b0, 32'h44, 32'h0, 4'hF, rd, er, gn, lt, bad);
    chk("pre-reset read", rd, 32'h5555AAAA);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h44;
    wait_gnt(1, gn);
    chk("rst read gnt_cycle", gn, 4);
    @(posedge CLK); #1;
    req[1] = 1'b0; res[1] = 1'b1;
    @(posedge CLK); #1;
    res[1] = 1'b0;
    @(negedge CLK);
    chk("rst r_valid", rv[1], 0);
    chk("rst gnt", gnt[1], 0);
    chk("rst rdata", rdata[1], 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      if (rv[1]) bad++;
    end
    chk("rst no late r_valid", bad, 0);
    @(posedge CLK); #1;

    // Reset in LAT after a write grant: the write stays committed.
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h48; wdata[1] = 32'h13579BDF; be[1] = 4'hF;
    wait_gnt(1, gn);
    chk("rst write gnt_cycle", gn, 4);
    @(posedge CLK); #1;
    req[1] = 1'b0; res[1] = 1'b1;
    @(posedge CLK); #1;
    res[1] = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (rv[1]) bad++;
      @(posedge CLK); #1;
    end
    chk("rst write no r_valid", bad, 0);
    txn(1, 1'b0, 32'h48, 32'h0, 4'hF, rd, er, gn, lt, bad);
    chk("rst write kept", rd, 32'h13579BDF);

    // Randomized LW/SW streams against a word-array model.
    for (int d = 0; d < 2; d++) begin
      egn = (d == 0) ? 1 : 4;
      elt = (d == 0) ? 1 : 2;
      for (int i = 0; i < 16; i++) begin
        wd = $urandom;
        txn(d, 1'b1, 32'h200 + 32'(4 * i), wd, 4'hF, rd, er, gn, lt, bad);
        mm[d][128 + i] = wd;
      end
      for (int i = 0; i < 40; i++) begin
        w  = (i < 20) ? 1'(i % 2) : 1'($urandom_range(0, 1));
        ix = 128 + int'($urandom_range(0, 15));
        a  = 32'(ix * 4);
        if (!eon) a = a + 32'($urandom_range(0, 7) * 4096);
        wd = $urandom;
        b  = (i < 20) ? 4'hF : 4'($urandom_range(0, 15));
        txn(d, w, a, wd, b, rd, er, gn, lt, bad);
        chk($sformatf("rnd d%0d #%0d gnt_cycle", d, i), gn, egn);
        chk($sformatf("rnd d%0d #%0d latency", d, i), lt, elt);
        chk($sformatf("rnd d%0d #%0d protocol", d, i), bad, 0);
        chk($sformatf("rnd d%0d #%0d err", d, i), er, 0);
        ix = int'(a >> 2) % 1024;
        if (w) begin
          chk($sformatf("rnd d%0d #%0d wr rdata", d, i), rd, 0);
          for (int k = 0; k < 4; k++) if (b[k]) mm[d][ix][8*k +: 8] = wd[8*k +: 8];
        end else begin
          chk($sformatf("rnd d%0d #%0d rd rdata", d, i), rd, mm[d][ix]);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
